// File: rtl/tmr_pkg.sv
// Shared definitions for the triplicated toggle decoder: lane indices,
// 2-of-3 majority and run-counter sizing.
package tmr_pkg;

  localparam int unsigned NUM_LANES = 3;
  localparam int unsigned LANE_A    = 0;
  localparam int unsigned LANE_B    = 1;
  localparam int unsigned LANE_C    = 2;

  typedef logic [NUM_LANES-1:0] lane_vec_t;

  function automatic logic maj3(input lane_vec_t v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  // Width that can hold the value fault_len itself (counter saturates there).
  function automatic int unsigned run_cnt_w(input int unsigned fault_len);
    return $clog2(fault_len + 1);
  endfunction

endpackage

// File: rtl/toggle_decode_voter_if.sv
// Bundle of the toggle lanes, clear strobe, decoded pulse and health status.
interface toggle_decode_voter_if import tmr_pkg::*; #(
  parameter int unsigned CNT_W = 8
) ();

  logic             in_a;
  logic             in_b;
  logic             in_c;
  logic             clr_err;
  logic             pulse_out;
  logic             voted_state;
  lane_vec_t        lane_err;
  lane_vec_t        lane_fault;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output in_a, in_b, in_c, clr_err,
    input  pulse_out, voted_state, lane_err, lane_fault, err_cnt
  );

  modport slave (
    input  in_a, in_b, in_c, clr_err,
    output pulse_out, voted_state, lane_err, lane_fault, err_cnt
  );

endinterface

// File: rtl/tmr_lane_monitor.sv
// Per-lane health tracker: sticky disagreement flag plus a run counter that
// flags a lane as faulty after FAULT_LEN consecutive disagreements.
module tmr_lane_monitor import tmr_pkg::*; #(
  parameter int unsigned FAULT_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic lane_i,
  input  logic maj_i,
  input  logic clr_err_i,
  output logic lane_err_o,
  output logic lane_fault_o
);

  localparam int unsigned      RUN_W   = run_cnt_w(FAULT_LEN);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(FAULT_LEN);

  logic [RUN_W-1:0] run_q, run_d;
  logic             err_q, err_d;
  logic             fault_q, fault_d;
  logic             disagree_c;

  assign disagree_c = lane_i ^ maj_i;

  always_comb begin
    run_d   = run_q;
    err_d   = err_q;
    fault_d = fault_q;
    if (clr_err_i) begin
      run_d   = '0;
      err_d   = 1'b0;
      fault_d = 1'b0;
    end else if (disagree_c) begin
      err_d = 1'b1;
      if (run_q != RUN_MAX) begin
        run_d = run_q + RUN_W'(1);
      end
      if (run_d == RUN_MAX) begin
        fault_d = 1'b1;
      end
    end else begin
      run_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q   <= '0;
      err_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      run_q   <= run_d;
      err_q   <= err_d;
      fault_q <= fault_d;
    end
  end

  assign lane_err_o   = err_q;
  assign lane_fault_o = fault_q;

endmodule

// File: rtl/toggle_decode_voter.sv
// Receive side of the triplicated toggle encoder: registers and votes the
// three lanes, turns voted toggles back into pulses and reports lane health.
module toggle_decode_voter import tmr_pkg::*; #(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned FAULT_LEN = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  toggle_decode_voter_if.slave    bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  lane_vec_t        in_q, in_d;
  logic             voted_q, voted_d;
  logic             pulse_q, pulse_d;
  logic             ld1_q, ld1_d;
  logic             ld2_q, ld2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             maj_c;
  lane_vec_t        mis_c;
  lane_vec_t        lane_err_w;
  lane_vec_t        lane_fault_w;

  assign maj_c = maj3(in_q);
  assign mis_c = in_q ^ {NUM_LANES{maj_c}};

  // ld1/ld2 mark the input and vote stages as holding real samples; a pulse
  // is only decoded once the vote stage has a predecessor to compare with,
  // so an encoder powering up at 1 does not produce a spurious pulse.
  always_comb begin
    in_d         = '0;
    in_d[LANE_A] = bus.in_a;
    in_d[LANE_B] = bus.in_b;
    in_d[LANE_C] = bus.in_c;
    ld1_d        = 1'b1;
    ld2_d        = ld1_q;
    voted_d      = maj_c;
    pulse_d      = ld2_q & (maj_c ^ voted_q);
    cnt_d        = cnt_q;
    if (bus.clr_err) begin
      cnt_d = '0;
    end else if ((|mis_c) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q    <= '0;
      voted_q <= 1'b0;
      pulse_q <= 1'b0;
      ld1_q   <= 1'b0;
      ld2_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      in_q    <= in_d;
      voted_q <= voted_d;
      pulse_q <= pulse_d;
      ld1_q   <= ld1_d;
      ld2_q   <= ld2_d;
      cnt_q   <= cnt_d;
    end
  end

  // Faulty lanes keep voting; the monitors only report status.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    tmr_lane_monitor #(
      .FAULT_LEN (FAULT_LEN)
    ) u_mon (
      .clk          (clk),
      .rst          (rst),
      .lane_i       (in_q[i]),
      .maj_i        (maj_c),
      .clr_err_i    (bus.clr_err),
      .lane_err_o   (lane_err_w[i]),
      .lane_fault_o (lane_fault_w[i])
    );
  end

  assign bus.pulse_out   = pulse_q;
  assign bus.voted_state = voted_q;
  assign bus.lane_err    = lane_err_w;
  assign bus.lane_fault  = lane_fault_w;
  assign bus.err_cnt     = cnt_q;

endmodule

// File: tb/tb_toggle_decode_voter.sv
// Bench for toggle_decode_voter: directed scenarios with literal expectations
// plus randomized traffic, all checked every cycle against a history model.
module tb_toggle_decode_voter;
  import tmr_pkg::*;

  localparam int unsigned CNT_W     = 3;
  localparam int unsigned FAULT_LEN = 4;
  localparam int          CNT_MAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  toggle_decode_voter_if #(.CNT_W(CNT_W)) bus ();

  toggle_decode_voter #(
    .CNT_W     (CNT_W),
    .FAULT_LEN (FAULT_LEN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: every lane sample seen since reset, and the index of the first
  // sample that still counts towards status after the latest clear.
  logic [2:0] hist[$];
  int         win = 0;

  function automatic logic vote(input logic [2:0] v);
    return (int'(v[0]) + int'(v[1]) + int'(v[2])) >= 2;
  endfunction

  task automatic compare();
    int         n;
    int         exp_cnt;
    int         run[3];
    logic       exp_v;
    logic       exp_p;
    logic [2:0] exp_err;
    logic [2:0] exp_flt;
    logic [2:0] s;
    logic       mv;
    n       = hist.size();
    exp_cnt = 0;
    run     = '{0, 0, 0};
    exp_v   = 1'b0;
    exp_p   = 1'b0;
    exp_err = '0;
    exp_flt = '0;
    if (n >= 2) exp_v = vote(hist[n-2]);
    if (n >= 3) exp_p = vote(hist[n-2]) != vote(hist[n-3]);
    for (int m = win; m <= n - 2; m++) begin
      s  = hist[m];
      mv = vote(s);
      if (s != {3{mv}} && exp_cnt < CNT_MAX) exp_cnt++;
      for (int l = 0; l < 3; l++) begin
        if (s[l] != mv) begin
          exp_err[l] = 1'b1;
          run[l]++;
          if (run[l] >= int'(FAULT_LEN)) exp_flt[l] = 1'b1;
        end else begin
          run[l] = 0;
        end
      end
    end
    check("model_voted_state", int'(bus.voted_state), int'(exp_v));
    check("model_pulse_out",   int'(bus.pulse_out),   int'(exp_p));
    check("model_lane_err",    int'(bus.lane_err),    int'(exp_err));
    check("model_lane_fault",  int'(bus.lane_fault),  int'(exp_flt));
    check("model_err_cnt",     int'(bus.err_cnt),     exp_cnt);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        hist.delete();
        win = 0;
      end else begin
        if (bus.clr_err) win = hist.size();
        hist.push_back({bus.in_c, bus.in_b, bus.in_a});
      end
      #1;
      compare();
    end
  end

  // One clock: drive at the falling edge, return 2 time units after rising.
  task automatic step(input logic [2:0] lanes, input logic clr);
    @(negedge clk);
    {bus.in_c, bus.in_b, bus.in_a} = lanes;
    bus.clr_err = clr;
    @(posedge clk);
    #2;
  endtask

  // Release lands between edges so the next step() drives edge 1.
  task automatic do_reset(input logic [2:0] lanes);
    @(negedge clk);
    rst = 1'b1;
    {bus.in_c, bus.in_b, bus.in_a} = lanes;
    bus.clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] seq[9];
    logic [2:0] lanes;
    logic       st;
    int         stuck_lane;
    int         stuck_left;

    {bus.in_c, bus.in_b, bus.in_a} = 3'b000;
    bus.clr_err = 1'b0;

    // Reset state
    do_reset(3'b000);
    check("reset_voted", int'(bus.voted_state), 0);
    check("reset_err_cnt", int'(bus.err_cnt), 0);

    // Clean decode: toggles sampled at edges 3, 4, 7
    seq = '{3'b000, 3'b000, 3'b111, 3'b000, 3'b000, 3'b000, 3'b111, 3'b111, 3'b111};
    for (int e = 1; e <= 9; e++) begin
      step(seq[e-1], 1'b0);
      check("clean_pulse", int'(bus.pulse_out), int'(e == 4 || e == 5 || e == 8));
    end
    check("clean_err_cnt", int'(bus.err_cnt), 0);
    check("clean_lane_err", int'(bus.lane_err), 0);

    // Power-up state 1
    do_reset(3'b111);
    for (int e = 1; e <= 6; e++) begin
      step(3'b111, 1'b0);
      check("pwrup_pulse", int'(bus.pulse_out), 0);
      if (e == 2) check("pwrup_voted", int'(bus.voted_state), 1);
    end

    // Single-lane glitch on b
    do_reset(3'b000);
    for (int e = 1; e <= 9; e++) begin
      st    = 1'(e & 1);
      lanes = {st, st, st};
      if (e == 4) lanes[LANE_B] = ~lanes[LANE_B];
      step(lanes, 1'b0);
    end
    check("glitch_lane_err", int'(bus.lane_err), 3'b010);
    check("glitch_err_cnt", int'(bus.err_cnt), 1);
    check("glitch_lane_fault", int'(bus.lane_fault), 0);

    // Persistent fault on c
    do_reset(3'b000);
    for (int e = 1; e <= 6; e++) begin
      st = 1'(e & 1);
      step({1'b0, st, st}, 1'b0);
    end
    check("persist_alt_fault", int'(bus.lane_fault), 0);
    for (int e = 7; e <= 10; e++) step(3'b011, 1'b0);
    check("persist_pre_fault", int'(bus.lane_fault), 0);
    step(3'b011, 1'b0);
    check("persist_fault", int'(bus.lane_fault), 3'b100);

    // Saturation then clear in a mismatch cycle
    do_reset(3'b000);
    for (int e = 1; e <= 10; e++) step(3'b001, 1'b0);
    check("sat_err_cnt", int'(bus.err_cnt), 7);
    check("sat_lane_err", int'(bus.lane_err), 3'b001);
    step(3'b001, 1'b1);
    check("clr_err_cnt", int'(bus.err_cnt), 0);
    check("clr_lane_err", int'(bus.lane_err), 0);
    check("clr_lane_fault", int'(bus.lane_fault), 0);
    step(3'b001, 1'b0);
    check("post_clr_err_cnt", int'(bus.err_cnt), 1);

    // Async reset mid-stream
    do_reset(3'b000);
    for (int e = 1; e <= 6; e++) begin
      st    = 1'(e & 1);
      lanes = {st, st, st};
      if (e == 3) lanes[LANE_C] = ~lanes[LANE_C];
      step(lanes, 1'b0);
    end
    check("pre_rst_voted", int'(bus.voted_state), 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    {bus.in_c, bus.in_b, bus.in_a} = 3'b111;
    #1;
    check("async_voted", int'(bus.voted_state), 0);
    check("async_pulse", int'(bus.pulse_out), 0);
    check("async_lane_err", int'(bus.lane_err), 0);
    check("async_err_cnt", int'(bus.err_cnt), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      step(3'b111, 1'b0);
      check("post_rst_pulse", int'(bus.pulse_out), 0);
    end

    // Randomized traffic with glitches, stuck-lane bursts and clears
    do_reset(3'b000);
    st         = 1'b0;
    stuck_lane = 0;
    stuck_left = 0;
    for (int i = 0; i < 400; i++) begin
      st    = st ^ 1'($urandom_range(0, 1));
      lanes = {st, st, st};
      if (stuck_left == 0 && $urandom_range(0, 39) == 0) begin
        stuck_lane = int'($urandom_range(0, 2));
        stuck_left = int'($urandom_range(3, 8));
      end
      if (stuck_left > 0) begin
        lanes[stuck_lane] = ~st;
        stuck_left--;
      end else if ($urandom_range(0, 7) == 0) begin
        lanes[$urandom_range(0, 2)] = ~st;
      end
      step(lanes, 1'($urandom_range(0, 31) == 0));
    end
    step(3'b000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/toggle_decode_voter.md
# toggle_decode_voter

Receive-side counterpart of the triplicated toggle-state encoder: takes the three redundant toggle lines (each lane's state flips on every cycle its input was 1), majority-votes them, and recovers the original one-cycle input pulses. It also tracks lane disagreements with sticky per-lane flags, a saturating mismatch counter and per-lane persistent-fault detection. It sits at the consumer boundary, where triplicated state leaves the hardened domain and becomes a single qualified pulse plus health status.

## Interface
- `CNT_W`, 8: width of the saturating mismatch counter.
- `FAULT_LEN`, 4: consecutive disagreeing cycles that mark a lane faulty; legal range 1..255.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_a`, `in_b`, `in_c` in 1 each: the three toggle lines, synchronous to `clk`.
- `clr_err` in 1: synchronous clear of all error status.
- `pulse_out` out 1: decoded pulse, high for one cycle per voted toggle.
- `voted_state` out 1: registered majority of the lanes.
- `lane_err` out 3: sticky flags, one per lane, bit0=a, bit1=b, bit2=c. A bit sets when its lane disagrees with the majority.
- `lane_fault` out 3: sticky flags, one per lane. A bit sets when its lane disagrees for `FAULT_LEN` consecutive cycles.
- `err_cnt` out `CNT_W`: saturating count of cycles in which any lane disagreed.

## Operation
- **Stage 1:** `in_q` <= {`in_c`, `in_b`, `in_a`}.
- **Stage 2:** `voted_state` <= maj(`in_q`), and `prev_state` <= `voted_state`.
- **Pulse decode:** `pulse_out` = `voted_state` ^ `prev_state`, gated by `primed`.
  - `primed` is 0 after reset and becomes 1 on the first edge after stage 2 has loaded.
  - This prevents a spurious pulse when the encoder's power-up state is 1.
- **Mismatch:** evaluated on `in_q`; lane i disagrees when `in_q[i]` != maj(`in_q`).
  - With 1-bit lanes a majority always exists, so at most one lane disagrees per cycle.
- **`lane_err[i]`:** sets on a disagreement edge and holds until `clr_err` or `rst`.
- **`err_cnt`:** +1 per disagreement cycle and saturates at 2^`CNT_W`-1 (no wrap).
- **Run counter per lane:** width fits `FAULT_LEN`.
  - Increments while the lane disagrees and resets to 0 on agreement.
  - Reaching `FAULT_LEN` sets `lane_fault[i]` (sticky).
  - Once there, the run counter holds at `FAULT_LEN` and does not wrap.
- **`clr_err`:** zeroes `lane_err`, `lane_fault`, `err_cnt` and all run counters on the next edge.
  - Clear has priority: a mismatch in the same cycle is neither counted nor flagged.
  - Decode path (`voted_state`, `pulse_out`) is unaffected.
- **Faulty lanes stay in the vote.** Voting remains 2-of-3 on all lanes; `lane_fault` is status only.

## Timing
- **Reset values:** every output and internal register is 0 (`primed`=0, `pulse_out`=0).
- **Pulse latency:** a lane transition sampled at edge k reaches `voted_state` at edge k+1. `pulse_out` is high for exactly the cycle following edge k+1.
- **Back-to-back toggles** (encoder input held 1): `pulse_out` stays high continuously, one pulse per cycle.
- **Status latency:** `lane_err` and `err_cnt` update at edge k+1 for a mismatch present at the inputs before edge k. `lane_fault` sets at the edge that completes the `FAULT_LEN`-th consecutive disagreeing `in_q` sample.
- **Reset mid-operation:** all state clears immediately (asynchronous). The first voted value after reset release produces no pulse.
- **Lane flips in a cycle where the majority does not change:** no pulse, mismatch counted.

## Structure
- **Shared package (`tmr_pkg`):**
  - `maj3` function.
  - Lane index constants `LANE_A`=0, `LANE_B`=1, `LANE_C`=2.
  - Run-counter width helper derived from `FAULT_LEN`.
- **Sub-module `tmr_lane_monitor`:** instantiated ×3.
  - Inputs: lane bit, voted bit, `clr_err`.
  - Outputs: `lane_err` and `lane_fault` bits.
  - Holds the run counter.
- **Top level:** input register, vote, decode, `primed` flag and `err_cnt`.

## Test plan
- **Clean decode:** reset, then all lanes toggle at edges 3, 4 and 7 → `pulse_out` high in the cycles after edges 4, 5 and 8; `err_cnt`=0; `lane_err`=0.
- **Power-up state 1:** lanes held at 1 from reset release → `voted_state`=1 after 2 edges, `pulse_out` never asserted.
- **Single-lane glitch:** `in_b` inverted for one cycle while a and c toggle normally → `pulse_out` sequence unchanged; `lane_err`=3'b010; `err_cnt`=1; `lane_fault`=0.
- **Persistent fault:** `in_c` stuck at 0 while a and b toggle each cycle for 6 cycles.
  - c disagrees on alternate cycles → `lane_fault[2]` stays 0.
  - Then hold a=b=1, c=0 for 4 cycles → `lane_fault`=3'b100.
  - Decoded pulses remain correct throughout.
- **Saturation with `CNT_W`=3:** 10 mismatch cycles → `err_cnt`=7. Assert `clr_err` in a mismatch cycle → `err_cnt`=0 and `lane_err`=0 on the next edge.
- **Async reset mid-stream:** assert `rst` between edges during toggling → outputs read 0 before the next edge. After release with lanes at 1 → no pulse.
